snake_body: RTL
===============

SNAKE_BODY -- requirements
Module: snake_body

Interface
REQ-001 SHALL have parameter MAX_LEN, default 32, maximum number of body segments (power of two, 4..64).
REQ-002 SHALL have parameter INIT_LEN, default 3, segment count after reset (2..MAX_LEN).
REQ-003 SHALL have port clk, input, 1, single clock for all logic.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port step, input, 1, one-cycle pulse from the movement stage: headPos holds the new head.
REQ-006 SHALL have port headPos, input, 8, {x[3:0], y[3:0]}; x 0..15, y 0..7 valid.
REQ-007 SHALL have port grow, input, 1, one-cycle pulse from the food logic requesting one extra segment.
REQ-008 SHALL have port tailPos, output, 8, {x,y} of the current tail segment.
REQ-009 SHALL have port length, output, 7, current segment count.
REQ-010 SHALL have port pixelReg, output, 128, bit y*16+x set when a segment occupies (x,y); feeds the display stage.
REQ-011 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-012 SHALL have port gameOver, output, 1, sticky collision flag.

Function
REQ-013 SHALL implement FSM states IDLE, CHECK, UPDATE, DEAD.
REQ-014 In IDLE, step SHALL be sampled; step -> CHECK (latch headPos and pending-grow into working registers).
REQ-015 Step arriving when not IDLE SHALL be ignored with no state change.
REQ-016 grow SHALL set a pending-grow flag in any state except DEAD; it is consumed by the next UPDATE.
REQ-017 CHECK SHALL compare the latched head against one stored segment per cycle, tail to head, for length cycles.
REQ-018 The tail segment SHALL be excluded from the comparison when pending-grow is clear.
REQ-019 Any match or latched y >= 8 SHALL transition to DEAD; otherwise CHECK -> UPDATE after the last comparison.
REQ-020 UPDATE SHALL push the head into the ring and set its pixelReg bit.
REQ-021 UPDATE without grow SHALL pop the tail and clear its bit.
REQ-022 When the new head equals the popped tail, the head set SHALL take priority (bit stays 1).
REQ-023 UPDATE with grow SHALL increment length and skip the pop.
REQ-024 At length == MAX_LEN, grow SHALL be treated as no grow (length saturates).
REQ-025 pixelReg, tailPos and length SHALL change only on the edge leaving UPDATE, L+1 edges after the sampling edge (L = length before the step); UPDATE returns to IDLE.
REQ-026 DEAD SHALL hold gameOver=1, busy=1 and all outputs frozen; it is exited only by reset.

Reset
REQ-027 reset SHALL override everything and return to IDLE in one edge, including mid-CHECK or mid-UPDATE.
REQ-028 After reset: ring holds (0,0)..(INIT_LEN-1,0), tail (0,0), head (INIT_LEN-1,0).
REQ-029 After reset: length=INIT_LEN, tailPos=0x00, pixelReg bits 0..INIT_LEN-1 set and others 0.
REQ-030 After reset: gameOver=0, busy=0, pending-grow=0.

Configuration
REQ-031 Macro SNAKE_SELF_COLLIDE_EN defined: CHECK state and self-collision SHALL be present as specified.
REQ-032 Macro undefined: IDLE SHALL go directly to UPDATE (or DEAD on y >= 8); output latency 1 edge; body overlap is permitted.

Structure
REQ-033 Package snake_pkg SHALL hold COLS=16, ROWS=8, the 8-bit pos_t typedef, the FSM state enum and a pos-to-pixel-index function.
REQ-034 Segment storage SHALL be sub-module snake_ring: MAX_LEN x 8 circular buffer with head/tail pointers, push, pop and indexed read.

Verification
REQ-035 Reset -> length=3, tailPos=0x00, pixelReg=0x7, gameOver=0, busy=0.
REQ-036 step headPos=0x30, no grow -> after 4 edges pixelReg=0xE, tailPos=0x10, length=3.
REQ-037 grow pulse, then step headPos=0x30 -> pixelReg=0xF, tailPos=0x00, length=4.
REQ-038 step headPos=0x08 -> DEAD, gameOver=1, pixelReg unchanged; further steps ignored until reset.
REQ-039 Length 4 curled around (0,0),(1,0),(1,1),(0,1), head into (0,0) without grow -> no collision; same move with grow -> gameOver=1.
REQ-040 step again while busy=1 -> ignored; only the first step is committed; reset asserted mid-CHECK -> reset state on next edge.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared types for the snake body tracker.
// Grid size, position type, FSM states, pixel index helper.
package snake_pkg;

   localparam int COLS = 16;
   localparam int ROWS = 8;
   localparam int NPIX = COLS * ROWS;

   typedef logic [7:0] pos_t;

   typedef enum logic [1:0] {
      IDLE,
      CHECK,
      UPDATE,
      DEAD
   } state_t;

   // y*16+x; off-grid rows map to 0 and are never written.
   function automatic logic [6:0] pix_idx(pos_t p);
      return p[3] ? 7'd0 : {p[2:0], p[7:4]};
   endfunction

endpackage

// File: rtl/snake_if.sv
// Bus between movement/food logic and the snake body.
// master drives step/grow/headPos, slave reports the body.
interface snake_if;
   import snake_pkg::*;

   logic            step;
   pos_t            headPos;
   logic            grow;
   pos_t            tailPos;
   logic [6:0]      length;
   logic [NPIX-1:0] pixelReg;
   logic            busy;
   logic            gameOver;

   modport master (
      output step, headPos, grow,
      input  tailPos, length, pixelReg, busy, gameOver
   );

   modport slave (
      input  step, headPos, grow,
      output tailPos, length, pixelReg, busy, gameOver
   );

endinterface

// File: rtl/snake_ring.sv
// Circular segment store, tail-relative read port.
// Reset preloads a straight body along row 0.
module snake_ring
   import snake_pkg::*;
#(
   parameter int MAX_LEN  = 32,
   parameter int INIT_LEN = 3
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  pos_t                       push_data,
   input  logic                       pop,
   input  logic [$clog2(MAX_LEN)-1:0] rd_idx,
   output pos_t                       rd_data
);

   localparam int AW = $clog2(MAX_LEN);

   pos_t          mem [MAX_LEN];
   logic [AW-1:0] hp;
   logic [AW-1:0] tp;
   logic [AW-1:0] hn;

   assign hn      = hp + 1'b1;
   assign rd_data = mem[tp + rd_idx];

   // Pointer and storage update; push writes one past head.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < MAX_LEN; i++)
            mem[i] <= (i < INIT_LEN) ? pos_t'({4'(i), 4'h0}) : '0;
         hp <= AW'(INIT_LEN - 1);
         tp <= '0;
      end else begin
         if (push) begin
            mem[hn] <= push_data;
            hp      <= hn;
         end
         if (pop)
            tp <= tp + 1'b1;
      end
   end

endmodule

// File: rtl/snake_body.sv
// Snake body tracker: collision check, ring update, pixel map.
// SNAKE_SELF_COLLIDE_EN enables the per-segment CHECK scan.
module snake_body
   import snake_pkg::*;
#(
   parameter int MAX_LEN  = 32,
   parameter int INIT_LEN = 3
) (
   input logic     clk,
   input logic     reset,
   snake_if.slave  bus
);

   localparam int         AW    = $clog2(MAX_LEN);
   localparam logic [6:0] LMAX  = 7'(MAX_LEN);
   localparam logic [6:0] LINIT = 7'(INIT_LEN);

   state_t          state;
   pos_t            hd;
   pos_t            tail_q;
   pos_t            rd;
   logic            gq;
   logic            pend;
   logic            g_in;
   logic            hit;
   logic            push;
   logic            pop;
   logic [AW-1:0]   cnt;
   logic [AW-1:0]   rd_idx;
   logic [6:0]      len;
   logic [NPIX-1:0] pix;
   logic [NPIX-1:0] pix_n;

   function automatic logic [NPIX-1:0] init_pix();
      logic [NPIX-1:0] r;
      r = '0;
      for (int i = 0; i < INIT_LEN; i++)
         r[pix_idx(pos_t'({4'(i), 4'h0}))] = 1'b1;
      return r;
   endfunction

   snake_ring #(
      .MAX_LEN  (MAX_LEN),
      .INIT_LEN (INIT_LEN)
   ) u_ring (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (hd),
      .pop       (pop),
      .rd_idx    (rd_idx),
      .rd_data   (rd)
   );

   assign push   = (state == UPDATE);
   assign pop    = (state == UPDATE) && !gq;
   assign rd_idx = (state == UPDATE) ? AW'(1) : cnt;
   assign g_in   = (pend | bus.grow) && (len != LMAX);
   assign hit    = (rd == hd) && ((cnt != '0) || gq);

   // Tail clear first so a head landing on the old tail stays lit.
   always_comb begin
      pix_n = pix;
      if (!gq)
         pix_n[pix_idx(tail_q)] = 1'b0;
      pix_n[pix_idx(hd)] = 1'b1;
   end

   // Main FSM: sample step, scan body, commit move, or die.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         hd     <= '0;
         gq     <= 1'b0;
         pend   <= 1'b0;
         cnt    <= '0;
         len    <= LINIT;
         tail_q <= '0;
         pix    <= init_pix();
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.grow)
                  pend <= 1'b1;
               if (bus.step) begin
                  hd   <= bus.headPos;
                  gq   <= g_in;
                  pend <= 1'b0;
                  cnt  <= '0;
`ifdef SNAKE_SELF_COLLIDE_EN
                  state <= CHECK;
`else
                  state <= bus.headPos[3] ? DEAD : UPDATE;
`endif
               end
            end
            CHECK: begin
               if (bus.grow)
                  pend <= 1'b1;
               cnt <= cnt + 1'b1;
               if (hd[3] || hit)
                  state <= DEAD;
               else if (7'(cnt) == len - 7'd1)
                  state <= UPDATE;
            end
            UPDATE: begin
               if (bus.grow)
                  pend <= 1'b1;
               pix    <= pix_n;
               len    <= gq ? len + 7'd1 : len;
               tail_q <= gq ? tail_q : rd;
               state  <= IDLE;
            end
            DEAD: begin
               state <= DEAD;
            end
         endcase
      end
   end

   assign bus.tailPos  = tail_q;
   assign bus.length   = len;
   assign bus.pixelReg = pix;
   assign bus.busy     = (state != IDLE);
   assign bus.gameOver = (state == DEAD);

endmodule
